// File: rtl/alu_console.sv
// ALU console: strobe-loaded operands/opcode, registered ALU result and flags,
// and a scanned N-digit hex 7-segment display, all in one clock domain.
module alu_console #(
  parameter int WIDTH    = 32,
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    sw,
  input  logic                ld_a,
  input  logic                ld_b,
  input  logic                ld_op,
  input  logic [1:0]          disp_sel,
  output logic [3:0]          flags,
  output logic [N_DIGITS-1:0] an,
  output logic [7:0]          seg
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int MSB   = WIDTH - 1;

  // Returns {result, ZF, CF, OF, SF}.
  function automatic logic [WIDTH+3:0] alu_eval(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [3:0]       op);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic [SH_W-1:0]  sh;
    logic             cf;
    logic             of;
    sum = {1'b0, a} + {1'b0, b};
    sh  = b[SH_W-1:0];
    r   = '0;
    cf  = 1'b0;
    of  = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a ^ b;
      4'd3:  r = ~(a | b);
      4'd4: begin
        r  = sum[WIDTH-1:0];
        cf = sum[WIDTH];
        of = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      end
      4'd5: begin
        r  = a - b;
        cf = (a < b);
        of = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      end
      4'd6:  r = WIDTH'($signed(a) < $signed(b));
      4'd7:  r = WIDTH'(a < b);
      4'd8:  r = a << sh;
      4'd9:  r = a >> sh;
      4'd10: r = WIDTH'($signed(a) >>> sh);
      default: r = '0;
    endcase
    return {r, (r == '0), cf, of, r[MSB]};
  endfunction

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  logic [2:0]          sync1_q, sync2_q, hist_q, rise;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, result_q, result_d, disp_val;
  logic [3:0]          op_q, op_d, flags_q, flags_d, nib;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [7:0]          seg_q, seg_d;

  // Strobes are {ld_op, ld_b, ld_a}; only the synced rising edge loads.
  assign rise = sync2_q & ~hist_q;

  always_comb begin
    a_d  = rise[0] ? sw : a_q;
    b_d  = rise[1] ? sw : b_q;
    op_d = rise[2] ? sw[3:0] : op_q;
    {result_d, flags_d} = alu_eval(a_q, b_q, op_q);

    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    case (disp_sel)
      2'd0:    disp_val = result_q;
      2'd1:    disp_val = a_q;
      2'd2:    disp_val = b_q;
      default: disp_val = WIDTH'(flags_q);
    endcase
    // Shifting past the top of the value naturally yields '0' digits.
    nib   = 4'(disp_val >> {idx_q, 2'b00});
    an_d  = ~(N_DIGITS'(1) << idx_q);
    seg_d = glyph(nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      hist_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      an_q     <= '1;
      seg_q    <= 8'hFF;
    end else begin
      sync1_q  <= {ld_op, ld_b, ld_a};
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign flags = flags_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule
